// File: rtl/isqrt_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isqrt_seq_pkg : shared types and sizing helpers for isqrt_seq        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package isqrt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int n_iter(input int width, input int steps);
    return (steps > 0) ? (width / 2) / steps : 1;
  endfunction

  function automatic bit cfg_ok(input int width, input int steps);
    return (width >= 4) && (width % 2 == 0) && (steps >= 1) && ((width / 2) % steps == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isqrt_seq_if : request/result handshake bundle for isqrt_seq         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface isqrt_seq_if #(
  parameter int BIT_WIDTH = 12
);
  localparam int ROOT_W = BIT_WIDTH / 2;

  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] x_in;
  logic                 round_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [ROOT_W-1:0]    root;
  logic [ROOT_W:0]      rem;
  logic                 sat;

  modport master (
    output in_valid, x_in, round_in, out_ready,
    input  in_ready, out_valid, root, rem, sat
  );

  modport slave (
    input  in_valid, x_in, round_in, out_ready,
    output in_ready, out_valid, root, rem, sat
  );

endinterface
`default_nettype wire

// File: rtl/isqrt_seq_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isqrt_seq_step : one combinational restoring square-root digit step  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module isqrt_seq_step #(
  parameter int BIT_WIDTH = 12
) (
  input  wire logic [BIT_WIDTH-1:0] i_r,
  input  wire logic [BIT_WIDTH-1:0] i_c,
  input  wire logic [BIT_WIDTH-1:0] i_d,
  output logic      [BIT_WIDTH-1:0] o_r,
  output logic      [BIT_WIDTH-1:0] o_c,
  output logic      [BIT_WIDTH-1:0] o_d
);

  logic [BIT_WIDTH:0] w_sum;
  logic [BIT_WIDTH:0] w_diff;

  // One extra bit so the sign of r - (c+d) is visible in the MSB
  assign w_sum  = {1'b0, i_c} + {1'b0, i_d};
  assign w_diff = {1'b0, i_r} - w_sum;

  assign o_c = w_diff[BIT_WIDTH] ? (i_c >> 1) : ((i_c >> 1) + i_d);
  assign o_r = w_diff[BIT_WIDTH] ? i_r : w_diff[BIT_WIDTH-1:0];
  assign o_d = i_d >> 2;

endmodule
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isqrt_seq : multi-cycle integer square root, floor/nearest, handshake|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int BIT_WIDTH       = 12,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  wire logic  clk,
  input  wire logic  reset,
  input  wire logic  flush,
  isqrt_seq_if.slave bus
);

  localparam int ROOT_W = BIT_WIDTH / 2;
  localparam int N_ITER = n_iter(BIT_WIDTH, STEPS_PER_CYCLE);
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0]     c_LAST   = CNT_W'(N_ITER - 1);
  localparam logic [BIT_WIDTH-1:0] c_D_INIT = BIT_WIDTH'(1) << (BIT_WIDTH - 2);

  if (!cfg_ok(BIT_WIDTH, STEPS_PER_CYCLE)) begin : g_bad_cfg
    $error("isqrt_seq: BIT_WIDTH must be even and >=4, STEPS_PER_CYCLE must divide BIT_WIDTH/2");
  end

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [ROOT_W-1:0]    r_root;
  logic [ROOT_W:0]      r_rem;
  logic                 r_sat;
  logic [BIT_WIDTH-1:0] r_work;
  logic [BIT_WIDTH-1:0] r_c;
  logic [BIT_WIDTH-1:0] r_d;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_round;

  logic [BIT_WIDTH-1:0] w_r [0:STEPS_PER_CYCLE];
  logic [BIT_WIDTH-1:0] w_c [0:STEPS_PER_CYCLE];
  logic [BIT_WIDTH-1:0] w_d [0:STEPS_PER_CYCLE];

  assign w_r[0] = r_work;
  assign w_c[0] = r_c;
  assign w_d[0] = r_d;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_chain
    isqrt_seq_step #(.BIT_WIDTH(BIT_WIDTH)) u_step (
      .i_r (w_r[g]),
      .i_c (w_c[g]),
      .i_d (w_d[g]),
      .o_r (w_r[g+1]),
      .o_c (w_c[g+1]),
      .o_d (w_d[g+1])
    );
  end

  logic [ROOT_W-1:0] w_floor;
  logic [ROOT_W:0]   w_rem;
  logic              w_round_up;
  logic              w_sat;
  logic [ROOT_W-1:0] w_root;
  logic              w_unused;

  // After the last step the root and remainder fit in their narrower result fields
  assign w_floor    = w_c[STEPS_PER_CYCLE][ROOT_W-1:0];
  assign w_rem      = w_r[STEPS_PER_CYCLE][ROOT_W:0];
  assign w_unused   = ^{w_c[STEPS_PER_CYCLE][BIT_WIDTH-1:ROOT_W],
                        w_r[STEPS_PER_CYCLE][BIT_WIDTH-1:ROOT_W+1]};
  assign w_round_up = r_round && ({1'b0, w_floor} < w_rem);
  assign w_sat      = w_round_up && (&w_floor);
  assign w_root     = (w_round_up && !w_sat) ? w_floor + ROOT_W'(1) : w_floor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_root      <= '0;
      r_rem       <= '0;
      r_sat       <= 1'b0;
      r_work      <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_round     <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_work     <= bus.x_in;
            r_round    <= bus.round_in;
            r_c        <= '0;
            r_d        <= c_D_INIT;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_work <= w_r[STEPS_PER_CYCLE];
          r_c    <= w_c[STEPS_PER_CYCLE];
          r_d    <= w_d[STEPS_PER_CYCLE];
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_root      <= w_root;
            r_rem       <= w_rem;
            r_sat       <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.root      = r_root;
  assign bus.rem       = r_rem;
  assign bus.sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_isqrt_seq : directed and sweep checks of isqrt_seq (1, 3, 6 steps)|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_isqrt_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush1 = 1'b0;
  logic flush3 = 1'b0;
  logic flush6 = 1'b0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  isqrt_seq_if #(.BIT_WIDTH(12)) bus1 ();
  isqrt_seq_if #(.BIT_WIDTH(12)) bus3 ();
  isqrt_seq_if #(.BIT_WIDTH(12)) bus6 ();

  isqrt_seq #(.BIT_WIDTH(12), .STEPS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset), .flush(flush1), .bus(bus1));
  isqrt_seq #(.BIT_WIDTH(12), .STEPS_PER_CYCLE(3)) u_dut3 (.clk(clk), .reset(reset), .flush(flush3), .bus(bus3));
  isqrt_seq #(.BIT_WIDTH(12), .STEPS_PER_CYCLE(6)) u_dut6 (.clk(clk), .reset(reset), .flush(flush6), .bus(bus6));

  function automatic void ref_model(input int x, input int rnd, output int root, output int rem, output int sat);
    int f = 0;
    while ((f + 1) * (f + 1) <= x) f++;
    rem  = x - f * f;
    root = f;
    sat  = 0;
    if (rnd != 0 && rem > f) begin
      if (f == 63) sat = 1;
      else root = f + 1;
    end
  endfunction

  // Issue one request on the single-step DUT and collect its result
  task automatic drive1(input logic [11:0] x, input logic rnd, output logic [5:0] root,
                        output logic [6:0] rem, output logic sat, output int lat);
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.x_in = x; bus1.round_in = rnd; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    root = bus1.root; rem = bus1.rem; sat = bus1.sat;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus1.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus1.in_ready); else passed++;
    checks++; if (bus1.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus1.out_valid); else passed++;
    checks++; if (bus1.root !== 6'd0) $display("FAIL reset_root got %0d want 0", bus1.root); else passed++;
    checks++; if (bus1.rem !== 7'd0) $display("FAIL reset_rem got %0d want 0", bus1.rem); else passed++;
    checks++; if (bus1.sat !== 1'b0) $display("FAIL reset_sat got %b want 0", bus1.sat); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_vectors(input logic rnd);
    int xs[7]  = '{0, 1, 4, 15, 110, 143, 4095};
    int er0[7] = '{0, 1, 2, 3, 10, 11, 63};
    int er1[7] = '{0, 1, 2, 4, 10, 12, 63};
    int erm[7] = '{0, 0, 0, 6, 10, 22, 126};
    int es1[7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [5:0] root; logic [6:0] rem; logic sat; int lat;
    for (int i = 0; i < 7; i++) begin
      int eroot = rnd ? er1[i] : er0[i];
      int esat  = rnd ? es1[i] : 0;
      drive1(12'(xs[i]), rnd, root, rem, sat, lat);
      checks++; if (root !== 6'(eroot)) $display("FAIL root x=%0d rnd=%b got %0d want %0d", xs[i], rnd, root, eroot); else passed++;
      checks++; if (rem !== 7'(erm[i])) $display("FAIL rem x=%0d rnd=%b got %0d want %0d", xs[i], rnd, rem, erm[i]); else passed++;
      checks++; if (sat !== 1'(esat)) $display("FAIL sat x=%0d rnd=%b got %b want %0d", xs[i], rnd, sat, esat); else passed++;
      checks++; if (lat != 7) $display("FAIL latency x=%0d got %0d want 7", xs[i], lat); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] root; logic [6:0] rem; logic sat; int lat;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    bus1.x_in = 12'd200; bus1.round_in = 1'b0; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus1.out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got %b want 1", i, bus1.out_valid); else passed++;
      checks++; if (bus1.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got %b want 0", i, bus1.in_ready); else passed++;
      checks++; if (bus1.root !== 6'd14) $display("FAIL bp_root cyc=%0d got %0d want 14", i, bus1.root); else passed++;
      checks++; if (bus1.rem !== 7'd4) $display("FAIL bp_rem cyc=%0d got %0d want 4", i, bus1.rem); else passed++;
    end
    @(negedge clk); bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus1.out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", bus1.out_valid); else passed++;
    checks++; if (bus1.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", bus1.in_ready); else passed++;
    drive1(12'd50, 1'b0, root, rem, sat, lat);
    checks++; if (root !== 6'd7 || rem !== 7'd1) $display("FAIL bp_next got %0d/%0d want 7/1", root, rem); else passed++;
  endtask

  task automatic test_back_to_back();
    int t = 0; int hits = 0; int first = -1; int second = -1;
    @(negedge clk);
    bus1.out_ready = 1'b1; bus1.x_in = 12'd9; bus1.round_in = 1'b0; bus1.in_valid = 1'b1;
    while (t < 40 && hits < 2) begin
      @(posedge clk); #1; t++;
      if (bus1.out_valid) begin
        if (hits == 0) first = t; else second = t;
        hits++;
        checks++; if (bus1.root !== 6'd3) $display("FAIL b2b_root got %0d want 3", bus1.root); else passed++;
      end
    end
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (first != 7) $display("FAIL b2b_first got %0d want 7", first); else passed++;
    checks++; if (second != 15) $display("FAIL b2b_second got %0d want 15", second); else passed++;
  endtask

  task automatic test_flush();
    int stale; int lat; logic [5:0] root; logic [6:0] rem; logic sat;
    // flush while BUSY
    @(negedge clk); bus1.x_in = 12'd100; bus1.round_in = 1'b0; bus1.in_valid = 1'b1;
    @(posedge clk); #1; bus1.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); flush1 = 1'b1;
    @(posedge clk); #1; flush1 = 1'b0;
    checks++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) $display("FAIL flush_busy got v=%b r=%b want v=0 r=1", bus1.out_valid, bus1.in_ready); else passed++;
    stale = 0;
    repeat (10) begin @(posedge clk); #1; if (bus1.out_valid) stale++; end
    checks++; if (stale != 0) $display("FAIL flush_busy_stale got %0d want 0", stale); else passed++;
    // flush while DONE
    bus1.out_ready = 1'b0;
    @(negedge clk); bus1.in_valid = 1'b1;
    @(posedge clk); #1; bus1.in_valid = 1'b0; lat = 1;
    while (!bus1.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (bus1.out_valid !== 1'b1) $display("FAIL flush_done_setup got %b want 1", bus1.out_valid); else passed++;
    @(negedge clk); flush1 = 1'b1;
    @(posedge clk); #1; flush1 = 1'b0; bus1.out_ready = 1'b1;
    checks++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) $display("FAIL flush_done got v=%b r=%b want v=0 r=1", bus1.out_valid, bus1.in_ready); else passed++;
    stale = 0;
    repeat (10) begin @(posedge clk); #1; if (bus1.out_valid) stale++; end
    checks++; if (stale != 0) $display("FAIL flush_done_stale got %0d want 0", stale); else passed++;
    // flush in IDLE blocks a simultaneous request
    @(negedge clk); flush1 = 1'b1; bus1.x_in = 12'd16; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus1.in_ready !== 1'b1) $display("FAIL flush_idle_accept got in_ready=%b want 1", bus1.in_ready); else passed++;
    @(negedge clk); flush1 = 1'b0; bus1.in_valid = 1'b0;
    stale = 0;
    repeat (10) begin @(posedge clk); #1; if (bus1.out_valid) stale++; end
    checks++; if (stale != 0) $display("FAIL flush_idle_stale got %0d want 0", stale); else passed++;
    drive1(12'd16, 1'b0, root, rem, sat, lat);
    checks++; if (root !== 6'd4 || rem !== 7'd0) $display("FAIL flush_recover got %0d/%0d want 4/0", root, rem); else passed++;
  endtask

  task automatic test_reset_mid();
    int stale; int lat; logic [5:0] root; logic [6:0] rem; logic sat;
    @(negedge clk); bus1.x_in = 12'd300; bus1.round_in = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1; bus1.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) $display("FAIL reset_mid got v=%b r=%b want v=0 r=1", bus1.out_valid, bus1.in_ready); else passed++;
    @(negedge clk); reset = 1'b0;
    stale = 0;
    repeat (10) begin @(posedge clk); #1; if (bus1.out_valid) stale++; end
    checks++; if (stale != 0) $display("FAIL reset_mid_stale got %0d want 0", stale); else passed++;
    drive1(12'd300, 1'b1, root, rem, sat, lat);
    checks++; if (root !== 6'd17 || rem !== 7'd11 || sat !== 1'b0) $display("FAIL reset_recover got %0d/%0d/%b want 17/11/0", root, rem, sat); else passed++;
  endtask

  task automatic sweep3();
    int er, erm, es, lat, nfail;
    nfail = 0;
    for (int x = 0; x < 4096; x++) begin
      for (int m = 0; m < 2; m++) begin
        @(negedge clk); bus3.x_in = 12'(x); bus3.round_in = 1'(m); bus3.in_valid = 1'b1;
        @(posedge clk); #1; bus3.in_valid = 1'b0; lat = 1;
        while (!bus3.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        ref_model(x, m, er, erm, es);
        checks++;
        if (bus3.root !== 6'(er) || bus3.rem !== 7'(erm) || bus3.sat !== 1'(es) || lat != 3) begin
          nfail++;
          if (nfail <= 10) $display("FAIL sweep3 x=%0d rnd=%0d got %0d/%0d/%b lat %0d want %0d/%0d/%0d lat 3", x, m, bus3.root, bus3.rem, bus3.sat, lat, er, erm, es);
        end else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic sweep6();
    int er, erm, es, lat, nfail;
    nfail = 0;
    for (int x = 0; x < 4096; x++) begin
      for (int m = 0; m < 2; m++) begin
        @(negedge clk); bus6.x_in = 12'(x); bus6.round_in = 1'(m); bus6.in_valid = 1'b1;
        @(posedge clk); #1; bus6.in_valid = 1'b0; lat = 1;
        while (!bus6.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        ref_model(x, m, er, erm, es);
        checks++;
        if (bus6.root !== 6'(er) || bus6.rem !== 7'(erm) || bus6.sat !== 1'(es) || lat != 2) begin
          nfail++;
          if (nfail <= 10) $display("FAIL sweep6 x=%0d rnd=%0d got %0d/%0d/%b lat %0d want %0d/%0d/%0d lat 2", x, m, bus6.root, bus6.rem, bus6.sat, lat, er, erm, es);
        end else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus1.in_valid = 1'b0; bus1.x_in = '0; bus1.round_in = 1'b0; bus1.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.x_in = '0; bus3.round_in = 1'b0; bus3.out_ready = 1'b1;
    bus6.in_valid = 1'b0; bus6.x_in = '0; bus6.round_in = 1'b0; bus6.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_vectors(1'b0);
    test_vectors(1'b1);
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    fork
      sweep3();
      sweep6();
    join
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
